fu_issue_buffer: RTL
====================

Name: fu_issue_buffer

Overview:
- Receive side of the RS issue path. Sits between the stage-1 priority selector and one function unit.
- Captures ops granted to its FU type and holds them in a small in-order FIFO. Drains them to the FU under a valid/ready handshake.
- Drives the FU stall flag back to the selector so the selector masks requests for that FU type before the buffer overflows.
- One instance per FU (ALU0, MULT, ...); the stall output of the ALU0 instance feeds ALU0_stall_in.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PAYLOAD_WIDTH, 64, opaque issued-op bits (operands, dest tag, opcode); not interpreted.
- FU_TYPE, ALU, FUNC_UNIT value this instance accepts.
- SKID, 1, cycles between the stall assertion and the selector ceasing grants; 0 <= SKID < DEPTH.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  mispredict squash; empties the buffer.
- issue_valid  input  1  selector granted a slot this cycle.
- issue_func  input  FUNC_UNIT  FU type of the granted slot.
- issue_payload  input  PAYLOAD_WIDTH  granted op.
- out_valid  output  1  head entry present.
- out_payload  output  PAYLOAD_WIDTH  head entry.
- out_ready  input  1  FU accepts the head this cycle.
- stall_out  output  1  to selector (ALU0_stall_in for the ALU0 instance).
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow_err  output  1  sticky; a push was dropped.

Behaviour:
- Interface fixed: one clock, `clock`; reset is `reset`, synchronous and active-high.
- Reset, at the clock edge with reset=1:
  - count=0, out_valid=0, stall_out=0, overflow_err=0.
  - head/tail pointers=0; out_payload=0.
  - Storage contents are don't-care.
  - Reset overrides flush, push and pop.
- push = issue_valid && (issue_func == FU_TYPE). Mismatched FU types are ignored silently.
- pop = out_valid && out_ready.
- FIFO ordering:
  - First-word fall-through, strict in-order.
  - A push at edge N is visible on out_valid/out_payload after edge N; latency is 1 cycle.
  - An entry is never presented in the same cycle it is pushed (no bypass).
- Occupancy:
  - out_valid = (count != 0).
  - out_payload = head entry when out_valid, else all zeros.
- Simultaneous push and pop:
  - With 0 < count < DEPTH: count unchanged, both pointers advance.
  - With count == 0: pop is impossible; the push proceeds.
  - With count == DEPTH: the pop frees a slot and the push is accepted. Count stays DEPTH, no error.
- Overflow: push with count == DEPTH and no pop:
  - Payload dropped, count unchanged.
  - overflow_err set on the next edge and held until reset (flush does not clear it).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is one bit wider so that full and empty are distinct.
- stall_out is combinational from registered count: stall_out = (count >= DEPTH - SKID).
  - No dependence on out_ready. This avoids a combinational path FU -> selector.
  - SKID slots of headroom absorb the grant already in flight.
- flush=1 at an edge (and reset=0):
  - count=0, pointers=0, any same-cycle push and pop are discarded.
  - Next cycle: out_valid=0, stall_out=0 (unless DEPTH-SKID == 0, which is disallowed).
- No FSM beyond occupancy. Legal count range is 0..DEPTH; the assertion count <= DEPTH must hold always.

Decomposition:
- FUNC_UNIT typedef (2-bit enum incl. ALU) lives in the shared sys_defs package.
- Add localparam defaults there: FU_BUF_DEPTH and ISSUE_PAYLOAD_WIDTH.
- One natural sub-module: fu_fifo_core. It is a parameterised storage array with head/tail/count, push/pop/flush and full/empty.
- The top adds the FU_TYPE filter, the stall threshold and the sticky error.

Test Plan (DEPTH=4, SKID=1, FU_TYPE=ALU):
- Reset, then issue_valid=1, issue_func=ALU, payload 0xA1 at edge 1 -> after edge 1: out_valid=1, out_payload=0xA1, count=1, stall_out=0.
- Push 0x1,0x2,0x3 on consecutive edges with out_ready=0 -> count=3 and stall_out=1 after the third edge. A 4th push (0x4) is accepted: count=4, overflow_err=0. A 5th push (0x5) is dropped: overflow_err=1, count=4, head still 0x1.
- Full (0x1..0x4) with out_ready=1 and push 0x9 in the same edge -> count=4; drained order is 0x2,0x3,0x4,0x9; pointers wrap with no corruption.
- issue_valid=1 with issue_func=MULT (≠ALU) for 3 cycles -> count stays 0, out_valid=0.
- count=3, stall_out=1; assert flush together with push 0x7 and out_ready=1 -> after the edge: count=0, out_valid=0, stall_out=0, 0x7 never appears.
- Reset asserted mid-stream with count=2 and overflow_err=1 -> after the edge all outputs are at reset values, including overflow_err=0.

Source files
------------

// File: rtl/sys_defs.sv
// Shared RS/issue definitions: function-unit encoding and issue-buffer defaults.
package sys_defs;

    typedef enum logic [1:0] {
        ALU    = 2'd0,
        MULT   = 2'd1,
        MEM    = 2'd2,
        BRANCH = 2'd3
    } FUNC_UNIT;

    localparam int FU_BUF_DEPTH        = 4;
    localparam int ISSUE_PAYLOAD_WIDTH = 64;

endpackage

// File: rtl/fu_fifo_core.sv
// In-order first-word-fall-through storage with head/tail pointers and occupancy.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fu_fifo_core
    import sys_defs::*;
#(
    parameter int DEPTH = FU_BUF_DEPTH,
    parameter int WIDTH = ISSUE_PAYLOAD_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == {CNT_W{1'b0}});
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign count     = r_count;
    assign head_data = r_mem[r_head];

    // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; contents are don't-care after reset or flush.
    always_ff @(posedge clock) begin
        if (w_push_ok && !flush && !reset) begin
            r_mem[r_tail] <= wdata;
        end
    end

endmodule

// File: rtl/fu_issue_buffer_chk.sv
// Property checker for fu_issue_buffer occupancy invariants.
module fu_issue_buffer_chk #(
    parameter int DEPTH = 4
) (
    input logic                   clock,
    input logic                   reset,
    input logic                   out_valid,
    input logic [$clog2(DEPTH):0] count
);

    a_count_bound : assert property (@(posedge clock) disable iff (reset)
        count <= ($clog2(DEPTH) + 1)'(DEPTH));

    a_valid_tracks_count : assert property (@(posedge clock) disable iff (reset)
        out_valid == (count != '0));

endmodule

// File: rtl/fu_issue_buffer.sv
// Per-FU issue buffer: captures ops granted to FU_TYPE, drains them to the FU,
// and raises stall_out early enough that grants still in flight always fit.
module fu_issue_buffer
    import sys_defs::*;
#(
    parameter int       DEPTH         = FU_BUF_DEPTH,
    parameter int       PAYLOAD_WIDTH = ISSUE_PAYLOAD_WIDTH,
    parameter FUNC_UNIT FU_TYPE       = ALU,
    parameter int       SKID          = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     issue_valid,
    input  FUNC_UNIT                 issue_func,
    input  logic [PAYLOAD_WIDTH-1:0] issue_payload,
    output logic                     out_valid,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    input  logic                     out_ready,
    output logic                     stall_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [CNT_W-1:0]         w_count;
    logic [PAYLOAD_WIDTH-1:0] w_head_data;
    logic                     r_overflow_err;

    assign w_push = issue_valid && (issue_func == FU_TYPE);
    assign w_pop  = out_valid && out_ready;

    fu_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (PAYLOAD_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (w_push),
        .pop       (w_pop),
        .wdata     (issue_payload),
        .head_data (w_head_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign out_valid = !w_empty;
    assign count     = w_count;

    // Threshold on registered count only, so FU ready never reaches the selector.
    assign stall_out = (w_count >= CNT_W'(DEPTH - SKID));

    // Head presentation is zeroed when empty so stale storage never leaks out.
    always_comb begin
        out_payload = {PAYLOAD_WIDTH{1'b0}};
        if (out_valid) begin
            out_payload = w_head_data;
        end else begin
            out_payload = {PAYLOAD_WIDTH{1'b0}};
        end
    end

    // Sticky drop flag: only reset clears it, a flush leaves it visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow_err <= 1'b0;
        end else if (w_push && w_full && !w_pop && !flush) begin
            r_overflow_err <= 1'b1;
        end
    end

    assign overflow_err = r_overflow_err;

endmodule
